// File: rtl/ahb_pkg_hdl.sv
// Shared AHB-Lite types and constants for the HDL side of the AHB agent.
//   ahb_htrans_t      : transfer type encoding
//   ahb_hresp_t       : response encoding (OKAY/ERROR only, AHB-Lite)
//   ahb_resp_state_t  : responder data-phase FSM states
package ahb_pkg_hdl;

  localparam int AHB_MAX_WAIT_STATES = 3;
  localparam int AHB_MEM_DATA_W      = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } ahb_hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_resp_state_t;

endpackage

// File: rtl/ahb_mem_responder_ram.sv
// Register-array memory for the AHB responder.
//   clk/rst : clock, asynchronous active-high clear of every word
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
module ahb_mem_responder_ram
  import ahb_pkg_hdl::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = AHB_MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: 16-bit word memory window at ADDR_BASE with
// WAIT_STATES data-phase wait cycles per OKAY transfer and a two-cycle ERROR.
//   hclk, hreset          : clock, asynchronous active-high reset
//   hsel/haddr/htrans/hwrite/hsize/hburst/hwdata : address phase (hwdata is
//                           sampled together with the address)
//   hready/hresp/hrdata   : data-phase response, decoded from registered state
module ahb_mem_responder
  import ahb_pkg_hdl::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [15:0] hwdata,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [15:0] hrdata
);

  localparam int         ABIT    = DEPTH_LOG2 + 1;
  // Counter preload; only meaningful when WAIT_STATES > 0.
  localparam logic [1:0] WS_LOAD = 2'(WAIT_STATES - 1);

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr;
    logic [15:0]           wdata;
  } aph_t;

  ahb_resp_state_t state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  aph_t            aph_q;

  logic [31:0] offs;
  logic        accept, addr_err;
  logic        mem_we;
  logic [15:0] mem_rd;

  assign offs     = haddr - ADDR_BASE;
  assign accept   = hsel & htrans[1] & hready;
  assign addr_err = (haddr[31:ABIT] != ADDR_BASE[31:ABIT]) || (hsize > 3'b001);

  // Address-phase latches. The error flag is carried by the ERR1 state
  // itself rather than a separate register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      aph_q <= '0;
    end else if (accept) begin
      aph_q.idx   <= offs[DEPTH_LOG2:1];
      aph_q.wr    <= hwrite;
      aph_q.wdata <= hwdata;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive hready=1, so each may take the next
        // address phase (pipelined back-to-back transfers).
        state_d = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  assign hready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata = ((state_q == ST_DATA) && !aph_q.wr) ? mem_rd : 16'h0000;

  // Write commits on the edge that leaves DATA; a read accepted at that same
  // edge sees the new word in its own DATA cycle.
  assign mem_we = (state_q == ST_DATA) && aph_q.wr;

  ahb_mem_responder_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (16)
  ) u_ram (
    .clk   (hclk),
    .rst   (hreset),
    .we    (mem_we),
    .waddr (aph_q.idx),
    .wdata (aph_q.wdata),
    .raddr (aph_q.idx),
    .rdata (mem_rd)
  );

  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], offs[31:ABIT], offs[0]};

endmodule
